// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS boot-time program loader.
// Imported by the loader top level and its byte packer.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    DONE,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mips_prog_loader_byte_packer.sv
// Big-endian 8->32 assembler: the first byte of a word lands in bits 31:24.
// Emits a registered one-cycle word_valid pulse with the finished word.
module byte_packer
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_fire,
  input  logic [7:0]  in_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [23:0] sh;

  assign last_byte = in_fire &&
    (byte_idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= '0;
      sh         <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= last_byte;
      if (clr) begin
        byte_idx <= '0;
      end else if (in_fire) begin
        byte_idx <= byte_idx + 2'd1;
        sh       <= {sh[15:0], in_data};
        if (last_byte)
          word <= {sh, in_data};
      end
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Streams a length-prefixed program into instruction memory, holding
// the MIPS core in reset until the final word has been written.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int NUM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  loader_state_t state, nxt;

  logic        fire;
  logic        dfire;
  logic        start_ok;
  logic        wlast;
  logic [7:0]  hdr_hi;
  logic [15:0] hdr_n;
  logic [15:0] nwords;
  logic [15:0] wcnt;

  assign fire     = in_valid && in_ready;
  assign dfire    = fire && (state == DATA);
  assign start_ok = start && !busy;
  assign hdr_n    = {hdr_hi, in_data};

  byte_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .in_fire    (dfire),
    .in_data    (in_data),
    .last_byte  (wlast),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR:
        if (start) nxt = HDR_HI;
      HDR_HI:
        if (fire) nxt = HDR_LO;
      HDR_LO:
        if (fire) begin
          if (hdr_n == 16'd0)
            nxt = DONE;
          else if (hdr_n > 16'(NUM_WORDS))
            nxt = ERR;
          else
            nxt = DATA;
        end
      DATA:
        if (wlast && (wcnt == nwords - 16'd1))
          nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    core_rst_n = 1'b0;
    unique case (state)
      HDR_HI, HDR_LO, DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  // Address is latched with the last byte so it lines up with the
  // packer's registered write strobe one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_hi    <= '0;
      nwords    <= '0;
      wcnt      <= '0;
      imem_addr <= '0;
    end else begin
      if (start_ok)
        wcnt <= '0;
      if (fire && state == HDR_HI)
        hdr_hi <= in_data;
      if (fire && state == HDR_LO)
        nwords <= hdr_n;
      if (wlast) begin
        imem_addr <= ADDR_W'({wcnt, 2'b00});
        wcnt      <= wcnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed and randomized checks of the program loader against a
// queue-based model of the expected instruction-memory writes.
module tb_mips_prog_loader;

  localparam int ADDR_W = 8;
  localparam int NW     = 64;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  mips_prog_loader #(
    .ADDR_W    (ADDR_W),
    .NUM_WORDS (NW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic        dn;
    logic        cr;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] words[$];
  int n_assert = 0;
  int n_fail   = 0;

  always @(negedge clk)
    if (imem_we === 1'b1)
      wq.push_back('{imem_addr, imem_wdata, done, core_rst_n});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(in_ready),   0);
    chk({tag, "_we"},    32'(imem_we),    0);
    chk({tag, "_addr"},  32'(imem_addr),  0);
    chk({tag, "_wdata"}, imem_wdata,      0);
    chk({tag, "_core"},  32'(core_rst_n), 0);
    chk({tag, "_busy"},  32'(busy),       0);
    chk({tag, "_done"},  32'(done),       0);
    chk({tag, "_err"},   32'(err),        0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1)
      chk("stall_timeout", 32'(in_ready), 1);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends header + all of words[]; start is held during data byte spulse.
  task automatic load_words(input int maxgap, input int spulse);
    logic [15:0] n;
    logic [31:0] w;
    int bi;
    n = 16'(words.size());
    send_byte(n[15:8], 0);
    send_byte(n[7:0], maxgap ? $urandom_range(maxgap, 0) : 0);
    bi = 0;
    foreach (words[k]) begin
      w = words[k];
      for (int j = 0; j < 4; j++) begin
        if (bi == spulse) start = 1'b1;
        send_byte(w[31-8*j -: 8],
                  maxgap ? $urandom_range(maxgap, 0) : 0);
        start = 1'b0;
        bi++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wq.size()), 32'(words.size()));
    for (int k = 0; k < wq.size() && k < words.size(); k++) begin
      chk({tag, "_addr"}, 32'(wq[k].a), 32'(4 * k));
      chk({tag, "_data"}, wq[k].d, words[k]);
      chk({tag, "_done"}, 32'(wq[k].dn),
          32'(k == words.size() - 1));
      chk({tag, "_core"}, 32'(wq[k].cr),
          32'(k == words.size() - 1));
    end
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-word program at full rate
    wq.delete();
    words = '{32'h8C010000, 32'h20020005, 32'hAC020004};
    pulse_start();
    chk("t1_busy",  32'(busy), 1);
    chk("t1_ready", 32'(in_ready), 1);
    load_words(0, -1);
    chk("t1_lastwe",   32'(imem_we), 1);
    chk("t1_lastaddr", 32'(imem_addr), 8);
    chk("t1_lastdone", 32'(done), 1);
    chk("t1_lastcore", 32'(core_rst_n), 1);
    chk("t1_lastbusy", 32'(busy), 0);
    @(negedge clk);
    chk("t1_we_drop", 32'(imem_we), 0);
    check_writes("t1");

    // Empty program
    wq.delete();
    pulse_start();
    chk("t2_done_clr", 32'(done), 0);
    chk("t2_core_clr", 32'(core_rst_n), 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    chk("t2_done", 32'(done), 1);
    chk("t2_core", 32'(core_rst_n), 1);
    repeat (2) @(negedge clk);
    chk("t2_nwr", 32'(wq.size()), 0);

    // Oversize header: 65 words
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    in_data = 8'h8C;
    chk("t3_err",   32'(err), 1);
    chk("t3_ready", 32'(in_ready), 0);
    chk("t3_core",  32'(core_rst_n), 0);
    chk("t3_done",  32'(done), 0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("t3_err_hold", 32'(err), 1);
    chk("t3_nwr", 32'(wq.size()), 0);

    // Two random words with random valid gaps
    rand_words(2);
    pulse_start();
    chk("t4_err_clr", 32'(err), 0);
    load_words(3, -1);
    repeat (2) @(negedge clk);
    check_writes("t4");

    // Reset after 6 of 8 data bytes
    rand_words(2);
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++)
      send_byte(words[i / 4][31 - 8 * (i % 4) -: 8], 0);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_partial_nwr", 32'(wq.size()), 1);
    rst_n = 1'b1;
    @(negedge clk);
    wq.delete();
    rand_words(2);
    pulse_start();
    load_words(1, -1);
    repeat (2) @(negedge clk);
    check_writes("t5");

    // start during DATA is ignored
    wq.delete();
    rand_words(3);
    pulse_start();
    load_words(0, 5);
    chk("t6_done", 32'(done), 1);
    repeat (2) @(negedge clk);
    check_writes("t6");

    // Reload from DONE
    wq.delete();
    pulse_start();
    chk("t7_core", 32'(core_rst_n), 0);
    chk("t7_done", 32'(done), 0);
    chk("t7_busy", 32'(busy), 1);
    rand_words(1);
    load_words(2, -1);
    repeat (2) @(negedge clk);
    check_writes("t7");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
